choose: RTL and testbench



---
 rtl/choose.sv | 45 ++++
 tb/tb_choose.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/choose.sv
// SHA-256 Ch stage: ch = (e & f) ^ (~e & g), registered with a travelling valid bit.
// Latency: LATENCY clock edges from input capture to output (1..4).
// Backpressure: none; accepts one word per clock, out_valid mirrors in_valid delayed.
module choose #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] ch,
    output logic             out_valid
);

    logic [WIDTH-1:0] ch_dat;
    logic [WIDTH-1:0] stage_dat [LATENCY];
    logic             stage_vld [LATENCY];

    assign ch_dat = (e & f) ^ (~e & g);

    // Data registers load every cycle; only the valid bits qualify them, so
    // X on the data inputs while idle can never reach out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_dat[i] <= '0;
                stage_vld[i] <= 1'b0;
            end
        end else begin
            stage_dat[0] <= ch_dat;
            stage_vld[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                stage_dat[i] <= stage_dat[i-1];
                stage_vld[i] <= stage_vld[i-1];
            end
        end
    end

    assign ch        = stage_dat[LATENCY-1];
    assign out_valid = stage_vld[LATENCY-1];

endmodule

// File: tb/tb_choose.sv
// Directed and random self-check of choose at LATENCY 1, 3 and 4 driven by shared inputs.
module tb_choose;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] e, f, g;
    logic [31:0] ch1, ch3, ch4;
    logic        ov1, ov3, ov4;

    int checks = 0;
    int errors = 0;

    // Input history, one entry per rising edge, used by the reference model.
    localparam int HMAX = 20000;
    logic        hr [HMAX];
    logic        hv [HMAX];
    logic [31:0] he [HMAX];
    logic [31:0] hf [HMAX];
    logic [31:0] hg [HMAX];
    int          nedge = 0;

    logic [31:0] ve [5];
    logic [31:0] vf [5];
    logic [31:0] vg [5];
    logic [31:0] vx [5];

    int in_cnt = 0, o1 = 0, o3 = 0, o4 = 0;

    always #5 clk = ~clk;

    choose #(.WIDTH(32), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .e(e), .f(f), .g(g),
        .ch(ch1), .out_valid(ov1)
    );
    choose #(.WIDTH(32), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .e(e), .f(f), .g(g),
        .ch(ch3), .out_valid(ov3)
    );
    choose #(.WIDTH(32), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .e(e), .f(f), .g(g),
        .ch(ch4), .out_valid(ov4)
    );

    function automatic logic [31:0] ch_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = a[i] ? b[i] : c[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (nedge < HMAX) begin
            hr[nedge] = rst;
            hv[nedge] = in_valid;
            he[nedge] = e;
            hf[nedge] = f;
            hg[nedge] = g;
            nedge++;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word captured at edge c reaches the output of a LATENCY=lat stage after
    // edge c+lat-1; any reset in that window drops it and leaves zeros.
    task automatic model(input int lat, output logic v, output logic [31:0] d);
        int   c;
        logic r;
        c = nedge - lat;
        v = 1'b0;
        d = '0;
        if (c >= 0) begin
            r = 1'b0;
            for (int k = c; k < nedge; k++) r = r | hr[k];
            v = hv[c] & ~r;
            d = r ? 32'h0 : ch_ref(he[c], hf[c], hg[c]);
        end
    endtask

    task automatic check_dut(input string tag, input int lat, input logic ov,
                             input logic [31:0] chv);
        logic        v;
        logic [31:0] d;
        model(lat, v, d);
        chk({tag, "_valid"}, {31'b0, ov}, {31'b0, v});
        if (v) chk({tag, "_ch"}, chv, d);
    endtask

    task automatic chk_stage(input string tag, input logic ov, input logic [31:0] chv,
                             input int idx);
        if (idx >= 0 && idx < 5) begin
            chk({tag, "_valid"}, {31'b0, ov}, 32'd1);
            chk({tag, "_ch"}, chv, vx[idx]);
        end else begin
            chk({tag, "_idle"}, {31'b0, ov}, 32'd0);
        end
    endtask

    initial begin
        ve[0] = 32'h00000039; vf[0] = 32'h0000001A; vg[0] = 32'h0000006C; vx[0] = 32'h0000005C;
        ve[1] = 32'hFFFFFFFF; vf[1] = 32'hDEADBEEF; vg[1] = 32'h55555555; vx[1] = 32'hDEADBEEF;
        ve[2] = 32'h00000000; vf[2] = 32'h12345678; vg[2] = 32'hCAFEF00D; vx[2] = 32'hCAFEF00D;
        ve[3] = 32'hFFFF0000; vf[3] = 32'h12345678; vg[3] = 32'h9ABCDEF0; vx[3] = 32'h1234DEF0;
        ve[4] = 32'hAAAAAAAA; vf[4] = 32'hFFFFFFFF; vg[4] = 32'h00000000; vx[4] = 32'hAAAAAAAA;

        rst = 1'b1; in_valid = 1'b0; e = '0; f = '0; g = '0;
        tick();
        tick();
        chk("rst_l1_valid", {31'b0, ov1}, 32'd0);
        chk("rst_l1_ch", ch1, 32'd0);
        chk("rst_l3_valid", {31'b0, ov3}, 32'd0);
        chk("rst_l3_ch", ch3, 32'd0);
        chk("rst_l4_valid", {31'b0, ov4}, 32'd0);
        chk("rst_l4_ch", ch4, 32'd0);

        // Stream five directed words back to back, then idle with X on data.
        rst = 1'b0;
        for (int t = 0; t < 9; t++) begin
            if (t < 5) begin
                in_valid = 1'b1; e = ve[t]; f = vf[t]; g = vg[t];
            end else begin
                in_valid = 1'b0; e = 'x; f = 'x; g = 'x;
            end
            tick();
            chk_stage("stream_l1", ov1, ch1, t);
            chk_stage("stream_l3", ov3, ch3, t - 2);
            chk_stage("stream_l4", ov4, ch4, t - 3);
        end

        // Reset with two words in flight, combined with a valid input.
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1; e = ve[t]; f = vf[t]; g = vg[t];
            tick();
        end
        rst = 1'b1; in_valid = 1'b1; e = ve[2]; f = vf[2]; g = vg[2];
        tick();
        chk("flush_l1_valid", {31'b0, ov1}, 32'd0);
        chk("flush_l1_ch", ch1, 32'd0);
        chk("flush_l3_valid", {31'b0, ov3}, 32'd0);
        chk("flush_l3_ch", ch3, 32'd0);
        chk("flush_l4_valid", {31'b0, ov4}, 32'd0);
        chk("flush_l4_ch", ch4, 32'd0);
        rst = 1'b0; in_valid = 1'b0; e = 'x; f = 'x; g = 'x;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("after_flush_l1", {31'b0, ov1}, 32'd0);
            chk("after_flush_l3", {31'b0, ov3}, 32'd0);
            chk("after_flush_l4", {31'b0, ov4}, 32'd0);
        end

        // First edge with rst low after a reset captures normally.
        rst = 1'b1; in_valid = 1'b0; e = '0; f = '0; g = '0;
        tick();
        rst = 1'b0; in_valid = 1'b1; e = ve[0]; f = vf[0]; g = vg[0];
        tick();
        chk("post_rst_l1_valid", {31'b0, ov1}, 32'd1);
        chk("post_rst_l1_ch", ch1, 32'h0000005C);
        in_valid = 1'b0;
        for (int t = 0; t < 4; t++) tick();

        // Random traffic against the history model, then drain and tally.
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            e = $urandom; f = $urandom; g = $urandom;
            tick();
            if (in_valid) in_cnt++;
            if (ov1) o1++;
            if (ov3) o3++;
            if (ov4) o4++;
            check_dut("rnd_l1", 1, ov1, ch1);
            check_dut("rnd_l3", 3, ov3, ch3);
            check_dut("rnd_l4", 4, ov4, ch4);
        end
        in_valid = 1'b0; e = 'x; f = 'x; g = 'x;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (ov1) o1++;
            if (ov3) o3++;
            if (ov4) o4++;
            check_dut("drain_l1", 1, ov1, ch1);
            check_dut("drain_l3", 3, ov3, ch3);
            check_dut("drain_l4", 4, ov4, ch4);
        end
        chk("count_l1", o1, in_cnt);
        chk("count_l3", o3, in_cnt);
        chk("count_l4", o4, in_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
